// File: rtl/window_col_gen.sv
// window_col_gen: raster line buffer emitting 3-row pixel columns for the sort stage.
// Define BORDER_REPLICATE_EN to clamp the first two rows instead of suppressing them.
module window_col_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [3*DATA_WIDTH-1:0] out_data,
  output logic                    out_last
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  logic [CW-1:0]           col;
  logic [1:0]              row_seen;
  logic [CW-1:0]           col_eff;
  logic [1:0]              row_eff;
  logic [CW-1:0]           col_nxt;
  logic [1:0]              row_nxt;
  logic                    at_end;
  logic [DATA_WIDTH-1:0]   up1;
  logic [DATA_WIDTH-1:0]   up2;
  logic                    col_valid;
  logic [3*DATA_WIDTH-1:0] col_data;

  always_comb begin
    col_eff   = in_sof ? '0 : col;
    row_eff   = in_sof ? 2'd0 : row_seen;
    at_end    = (col_eff == LAST_COL);
    up1       = lb0[col_eff];
    up2       = lb1[col_eff];
    col_nxt   = col_eff + 1'b1;
    row_nxt   = row_eff;
    col_valid = 1'b0;
    col_data  = '0;
    if (at_end) begin
      col_nxt = '0;
      row_nxt = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
    end
`ifdef BORDER_REPLICATE_EN
    col_valid = 1'b1;
    unique case (1'b1)
      (row_eff == 2'd0): col_data = {in_data, in_data, in_data};
      (row_eff == 2'd1): col_data = {up1, up1, in_data};
      default:           col_data = {up2, up1, in_data};
    endcase
`else
    col_valid = (row_eff == 2'd2);
    col_data  = {up2, up1, in_data};
`endif
  end

  // Buffers are never cleared; row_seen gating keeps stale lines off the output.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb1[col_eff] <= up1;
      lb0[col_eff] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row_seen  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (in_valid) begin
        col       <= col_nxt;
        row_seen  <= row_nxt;
        out_valid <= col_valid;
        out_last  <= col_valid && at_end;
        if (col_valid) out_data <= col_data;
      end
    end
  end

endmodule

// File: doc/window_col_gen.md
# window_col_gen

Streaming line-buffer stage that sits directly upstream of the 3-input sorting comparator in the median/BLC filter path. Accepts one raster-order pixel per cycle and emits, for each accepted pixel, the vertically aligned 3-pixel column (two rows above plus the current row) packed in the comparator's input format. Two internal line buffers of IMG_WIDTH entries supply the previous rows.

## Interface
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per line; legal range 2 and up.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_sof qualify this cycle.
- in_sof  in  1  first pixel of frame; ignored when in_valid=0.
- in_data  in  DATA_WIDTH  pixel.
- out_valid  out  1  out_data holds a valid column.
- out_data  out  3*DATA_WIDTH  {row r-2, row r-1, row r}; MSB slice is oldest row.
- out_last  out  1  column came from last pixel of a line (col = IMG_WIDTH-1).

## Operation
- State: col counter (0..IMG_WIDTH-1, width $clog2(IMG_WIDTH)); row_seen counter saturating at 2; line buffers lb0 (row r-1) and lb1 (row r-2), each IMG_WIDTH x DATA_WIDTH.
- Accepted pixel = in_valid high. No backpressure; in_valid low: counters, buffers hold; out_valid low next cycle.
- Effective position: if in_sof, col_eff=0 and row_eff=0, regardless of counter state (mid-frame restart); else current counters.
- On accept at col_eff=c: read lb0[c], lb1[c]; write lb1[c] <= lb0[c], lb0[c] <= in_data.
- Counter update: c=IMG_WIDTH-1 -> col=0, row_seen=min(row_eff+1,2); else col=c+1, row_seen=row_eff.
- Output assembly (row_eff=2): out_data = {lb1[c], lb0[c], in_data}, out_valid=1.
- Rows 0 and 1: behaviour set by Configuration.
- out_last = 1 iff accepted pixel had c=IMG_WIDTH-1 and out_valid is asserted.
- Frame height not tracked; a frame ends only at the next in_sof. Rows past the frame's last are treated as normal rows.
- Line buffer contents are never cleared; stale data never reaches out_data (suppressed or clamped).

## Timing
- Latency 1 cycle: pixel accepted at cycle n -> out_valid/out_data/out_last at n+1.
- Throughput 1 pixel/cycle sustained; arbitrary in_valid gaps.
- Reset: out_valid=0, out_data=0, out_last=0, col=0, row_seen=0. Reset mid-frame abandons the frame; next accepted pixel is row 0 col 0 with or without in_sof.
- rst has priority over in_valid in the same cycle.
- Read and write of the same buffer address in one cycle: read returns the old (pre-write) value.

## Configuration
- BORDER_REPLICATE_EN undefined: rows 0 and 1 of each frame produce no output (out_valid=0); (H-2)*IMG_WIDTH columns per frame of height H.
- BORDER_REPLICATE_EN defined: every accepted pixel produces an output; missing rows clamped to row 0. Row 0: {in_data, in_data, in_data}. Row 1: {lb0[c], lb0[c], in_data}. Rows >=2 unchanged. H*IMG_WIDTH columns per frame.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_last=0 throughout and the cycle after release.
- IMG_WIDTH=4, macro off, 4x4 frame continuous, pixel=row*16+col, sof on (0,0) -> first out_valid one cycle after pixel 0x20 with out_data={0x00,0x10,0x20}; exactly 8 outputs; last={0x13,0x23,0x33} with out_last=1; out_last=1 only on col 3.
- Same frame with in_valid pattern 1,0,0,1,... -> identical output sequence, each output exactly 1 cycle after its input, out_valid=0 in gap cycles.
- Mid-frame restart: in_sof with pixel at row 2 col 1 -> no output for that pixel or the next 2*IMG_WIDTH-1; then output at new row 2 col 0 uses new-frame rows only.
- Macro on, same 4x4 frame -> 16 outputs; pixel 0x01 -> {0x01,0x01,0x01}; pixel 0x12 -> {0x02,0x02,0x12}; pixel 0x23 -> {0x03,0x13,0x23}.
- rst pulsed during row 2 col 2, then pixels resume without sof -> treated as row 0 col 0; macro off: no output until third resumed row.
